hdr_remap_deser: RTL
====================

Name: hdr_remap_deser

Overview:
Serial-to-parallel frame deserialiser with header remapping. It collects one bit per `valid` cycle, MSB first, into a frame of HDR_W header bits followed by PAY_W payload bits. Frames whose header equals MATCH_HDR are emitted with the header replaced by NEW_HDR and the payload passed unchanged. It is the parametrised successor of the fixed 12-bit A-to-5 rewriter and adds reset, an output strobe, mismatch policy, resync and counters.

Parameters:
- HDR_W, 4, header width in bits (>=1).
- PAY_W, 8, payload width in bits (>=1).
- MATCH_HDR, 4'hA, header value to be remapped (HDR_W bits).
- NEW_HDR, 4'h5, replacement header value (HDR_W bits).
- DROP_MISMATCH, 1, policy for a mismatched header: 1 = consume and discard the frame; 0 = emit it unchanged with hit=0.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in  in  1  serial data bit.
- valid  in  1  `in` is sampled only when valid=1; gaps of any length are allowed.
- sof  in  1  start-of-frame; qualified by valid. The bit sampled with sof=1 is header bit 0 (the MSB).
- out  out  HDR_W+PAY_W  last emitted frame, header in the MSBs.
- out_valid  out  1  one-cycle strobe marking a new `out`.
- hit  out  1  qualifies out_valid: 1 = header was remapped.
- drop  out  1  one-cycle pulse when a mismatched frame completes with DROP_MISMATCH=1.
- abort  out  1  one-cycle pulse when sof=1 arrives while a frame is partially received.
- hit_cnt  out  CNT_W  number of remapped frames, saturating.
- drop_cnt  out  CNT_W  number of dropped plus aborted frames, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=HDR, bit counter=0, shift register=0, out=0, out_valid=0, hit=0, drop=0, abort=0, hit_cnt=0, drop_cnt=0. Reset takes priority over all inputs.
- Reset mid-frame discards the partial frame and produces no pulse.
- FSM states:
  - HDR: shift in HDR_W bits. After the last header bit, latch match = (header == MATCH_HDR), then go to PAY.
  - PAY: shift in PAY_W bits. On the last payload bit, go to HDR. The sampling edge also registers the result:
    - match=1: out={NEW_HDR,payload}, out_valid=1, hit=1, hit_cnt+1.
    - match=0 and DROP_MISMATCH=0: out={rx_header,payload}, out_valid=1, hit=0.
    - match=0 and DROP_MISMATCH=1: out unchanged, out_valid=0, drop=1, drop_cnt+1.
- Latency: outputs are visible in the cycle after the edge that samples the final bit. Pulses last exactly one cycle.
- Back-to-back frames with no idle cycle are supported. A bit sampled in the strobe cycle is header bit 0 of the next frame.
- out holds its value until the next emitted frame.
- Only the bit counter position delimits frames; sof is not required on every frame. sof at bit position 0 is a no-op.
- sof=1 with valid=1 when bit counter != 0 (in HDR or PAY):
  - abort=1 and drop_cnt+1;
  - the partial frame is discarded;
  - the current bit becomes header bit 0 and state=HDR.
- sof with valid=0 is ignored.
- If the frame would complete on the same edge as an sof, sof wins. No out_valid is produced; that frame is aborted.
- Counters saturate at 2^CNT_W-1 and never wrap.
- hit and drop are never 1 in the same cycle. abort and out_valid are never 1 in the same cycle.

Decomposition:
- Package hdr_remap_pkg holds:
  - typedef state_t {HDR, PAY};
  - localparam FRAME_W = HDR_W+PAY_W;
  - localparam BCNT_W = $clog2(FRAME_W).
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output cnt). It is instantiated twice, for hit_cnt and drop_cnt.

Test Plan:
- Match: send serial bits 1010_0011_1100, valid continuous -> one cycle later out=12'h53C, out_valid=1, hit=1, hit_cnt=1.
- Mismatch, DROP_MISMATCH=1: send 0111_1111_1111 -> out_valid stays 0, drop=1 for one cycle, drop_cnt=1, out keeps its previous value.
- Mismatch, DROP_MISMATCH=0: send 0111_0000_0001 -> out=12'h701, out_valid=1, hit=0, hit_cnt unchanged.
- Gaps and back-to-back: send 12'hA5A with valid toggling 1/0, then 12'hAFF with no gap -> out=12'h55A, then exactly 12 valid cycles later out=12'h5FF. Two strobes total.
- Resync: send 6 bits of a frame, then sof=1 with 1010_1000_0001 -> abort pulse once, drop_cnt=1, then out=12'h581.
- Reset mid-frame: drive rst_n=0 for one cycle after 7 bits, then send a full 12'hA00 -> all outputs 0 during reset, then out=12'h500, hit_cnt=1, drop_cnt=0.

Source files
------------

// File: rtl/hdr_remap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdr_remap_pkg
// Description : Shared types and default sizing for the header-remapping
//               serial deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package hdr_remap_pkg;

  // Two-phase frame walk: header bits first, then payload bits.
  typedef enum logic [0:0] {
    HDR = 1'b0,
    PAY = 1'b1
  } state_t;

  // Default frame geometry: 4-bit header followed by 8-bit payload.
  localparam int HDR_W_DEF = 4;
  localparam int PAY_W_DEF = 8;
  localparam int FRAME_W   = HDR_W_DEF + PAY_W_DEF;
  localparam int BCNT_W    = $clog2(FRAME_W);

  // Width of a bit-position counter covering positions 0..frame_w-1.
  function automatic int bcnt_width(input int frame_w);
    return (frame_w < 2) ? 1 : $clog2(frame_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import hdr_remap_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] c_max = '1;

  logic [W-1:0] r_cnt;

  // Count one per inc pulse, holding at the maximum once reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hdr_remap_deser.sv
`default_nettype none
// ============================================================================
// Module      : hdr_remap_deser
// Description : MSB-first serial-to-parallel frame deserialiser. Frames whose
//               header equals MATCH_HDR are emitted with NEW_HDR in place of
//               the header; mismatches are dropped or passed through.
//               A start-of-frame mid-frame aborts and resynchronises.
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_remap_deser
  import hdr_remap_pkg::*;
#(
  parameter int               HDR_W         = HDR_W_DEF,
  parameter int               PAY_W         = PAY_W_DEF,
  parameter logic [HDR_W-1:0] MATCH_HDR     = 4'hA,
  parameter logic [HDR_W-1:0] NEW_HDR       = 4'h5,
  parameter bit               DROP_MISMATCH = 1'b1,
  parameter int               CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in,
  input  logic                   valid,
  input  logic                   sof,
  output logic [HDR_W+PAY_W-1:0] out,
  output logic                   out_valid,
  output logic                   hit,
  output logic                   drop,
  output logic                   abort,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int c_frame_w = HDR_W + PAY_W;
  localparam int c_bcnt_w  = bcnt_width(c_frame_w);

  localparam logic [c_bcnt_w-1:0] c_hdr_last   = c_bcnt_w'(HDR_W - 1);
  localparam logic [c_bcnt_w-1:0] c_frame_last = c_bcnt_w'(c_frame_w - 1);

  // Registered state. The shift register holds one bit fewer than a frame:
  // the final bit arrives on the input and completes the frame combinationally.
  state_t                r_state;
  logic [c_bcnt_w-1:0]   r_bcnt;
  logic [c_frame_w-2:0]  r_shift;
  logic                  r_match;
  logic [c_frame_w-1:0]  r_out;
  logic                  r_out_valid;
  logic                  r_hit;
  logic                  r_drop;
  logic                  r_abort;

  // Next-state values and single-cycle events.
  state_t                w_state_nxt;
  state_t                w_st;
  logic [c_bcnt_w-1:0]   w_bcnt_nxt;
  logic [c_bcnt_w-1:0]   w_pos;
  logic [c_frame_w-1:0]  w_frame;
  logic [c_frame_w-2:0]  w_shift_d;
  logic                  w_match_d;
  logic [c_frame_w-1:0]  w_out_d;
  logic                  w_emit;
  logic                  w_hit;
  logic                  w_drop;
  logic                  w_abort;

  // Everything received so far with the current input bit appended.
  assign w_frame = {r_shift, in};

  // Frame walk: resync on mid-frame sof, latch the header match, and decide
  // the fate of the frame on its last payload bit.
  always_comb begin
    w_state_nxt = r_state;
    w_st        = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_pos       = r_bcnt;
    w_shift_d   = r_shift;
    w_match_d   = r_match;
    w_out_d     = r_out;
    w_emit      = 1'b0;
    w_hit       = 1'b0;
    w_drop      = 1'b0;
    w_abort     = 1'b0;

    if (valid) begin
      w_shift_d = w_frame[c_frame_w-2:0];

      // A start-of-frame away from position 0 discards the partial frame;
      // the current bit is then processed as header bit 0.
      if (sof && (r_bcnt != '0)) begin
        w_abort = 1'b1;
        w_pos   = '0;
        w_st    = HDR;
      end

      w_bcnt_nxt  = w_pos + c_bcnt_w'(1);
      w_state_nxt = w_st;

      case (w_st)
        HDR: begin
          if (w_pos == c_hdr_last) begin
            w_match_d   = (w_frame[HDR_W-1:0] == MATCH_HDR);
            w_state_nxt = PAY;
          end
        end
        PAY: begin
          if (w_pos == c_frame_last) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = HDR;
            if (r_match) begin
              w_out_d = {NEW_HDR, w_frame[PAY_W-1:0]};
              w_emit  = 1'b1;
              w_hit   = 1'b1;
            end else if (!DROP_MISMATCH) begin
              w_out_d = w_frame;
              w_emit  = 1'b1;
            end else begin
              w_drop  = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = HDR;
        end
      endcase
    end
  end

  // State register and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= HDR;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_match     <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_drop      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_shift     <= w_shift_d;
      r_match     <= w_match_d;
      r_out       <= w_out_d;
      r_out_valid <= w_emit;
      r_hit       <= w_hit;
      r_drop      <= w_drop;
      r_abort     <= w_abort;
    end
  end

  // Aborts and drops can never coincide, so one increment per cycle suffices.
  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit),
    .cnt   (hit_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_drop | w_abort),
    .cnt   (drop_cnt)
  );

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign hit       = r_hit;
  assign drop      = r_drop;
  assign abort     = r_abort;

endmodule
`default_nettype wire
